// File: rtl/pb_port_master_if.sv
// Port-bus master interface: command stream in, response stream out,
// and the KCPSM6-style peripheral port bus.
interface pb_port_master_if;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] rsp_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] port_id;
    logic [7:0] out_port;
    logic [7:0] in_port;
    logic       write_strobe;
    logic       read_strobe;
    logic       busy;

    modport master (
        input  cmd_data, cmd_valid, rsp_ready, in_port,
        output cmd_ready, rsp_data, rsp_valid, port_id, out_port,
        output write_strobe, read_strobe, busy
    );

    modport slave (
        output cmd_data, cmd_valid, rsp_ready, in_port,
        input  cmd_ready, rsp_data, rsp_valid, port_id, out_port,
        input  write_strobe, read_strobe, busy
    );
endinterface

// File: rtl/pb_port_master.sv
// Byte-command driven initiator for the PicoBlaze port bus: W/R commands
// become port write/read cycles, results return on the response stream.
module pb_port_master #(
    parameter logic [7:0]  WR_OPCODE      = 8'h57,
    parameter logic [7:0]  RD_OPCODE      = 8'h52,
    parameter logic [7:0]  ACK_CODE       = 8'h2E,
    parameter logic [7:0]  ERR_CODE       = 8'h3F,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input logic           clk,
    input logic           reset,
    pb_port_master_if.master bus
);
    typedef enum logic [2:0] {
        IDLE, GET_ADDR, GET_DATA, BUS_SETUP, BUS_STROBE, RESP
    } state_t;

    state_t      state_q, state_d;
    logic        is_wr_q, is_wr_d;
    logic [7:0]  port_id_q, port_id_d;
    logic [7:0]  out_port_q, out_port_d;
    logic [7:0]  rsp_data_q, rsp_data_d;
    logic [15:0] cnt_q, cnt_d;

    logic cmd_ready;
    logic xfer;
    logic tmo;

    assign cmd_ready = (state_q == IDLE) || (state_q == GET_ADDR) ||
                       (state_q == GET_DATA);
    assign xfer = bus.cmd_valid && cmd_ready;
    assign tmo  = (cnt_q == TIMEOUT_CYCLES - 16'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            is_wr_q    <= 1'b0;
            port_id_q  <= 8'h00;
            out_port_q <= 8'h00;
            rsp_data_q <= 8'h00;
            cnt_q      <= 16'd0;
        end else begin
            state_q    <= state_d;
            is_wr_q    <= is_wr_d;
            port_id_q  <= port_id_d;
            out_port_q <= out_port_d;
            rsp_data_q <= rsp_data_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        is_wr_d    = is_wr_q;
        port_id_d  = port_id_q;
        out_port_d = out_port_q;
        rsp_data_d = rsp_data_q;
        cnt_d      = cnt_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = 16'd0;
                if (xfer) begin
                    if (bus.cmd_data == WR_OPCODE) begin
                        is_wr_d = 1'b1;
                        state_d = GET_ADDR;
                    end else if (bus.cmd_data == RD_OPCODE) begin
                        is_wr_d = 1'b0;
                        state_d = GET_ADDR;
                    end else begin
                        rsp_data_d = ERR_CODE;
                        state_d    = RESP;
                    end
                end
            end
            GET_ADDR, GET_DATA: begin
                // An arriving byte beats an expiring timeout.
                if (xfer) begin
                    cnt_d = 16'd0;
                    if (state_q == GET_ADDR) begin
                        port_id_d = bus.cmd_data;
                        state_d   = is_wr_q ? GET_DATA : BUS_SETUP;
                    end else begin
                        out_port_d = bus.cmd_data;
                        state_d    = BUS_SETUP;
                    end
                end else if (tmo) begin
                    cnt_d   = 16'd0;
                    state_d = IDLE;
                end else if (cnt_q != 16'hFFFF) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            BUS_SETUP: state_d = BUS_STROBE;
            BUS_STROBE: begin
                rsp_data_d = is_wr_q ? ACK_CODE : bus.in_port;
                state_d    = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.cmd_ready    = cmd_ready;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.rsp_valid    = (state_q == RESP);
    assign bus.port_id      = port_id_q;
    assign bus.out_port     = out_port_q;
    assign bus.write_strobe = (state_q == BUS_STROBE) && is_wr_q;
    assign bus.read_strobe  = (state_q == BUS_STROBE) && !is_wr_q;
    assign bus.busy         = (state_q != IDLE);
endmodule

// File: tb/tb_pb_port_master.sv
// Directed bench for pb_port_master with a response-byte scoreboard
// and a bus monitor counting strobe pulses.
module tb_pb_port_master;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pb_port_master_if bus ();

    pb_port_master #(.TIMEOUT_CYCLES(16'd8)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus.master)
    );

    logic [7:0] mem [256];
    assign bus.in_port = mem[bus.port_id];

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q [$];

    int ws_cnt = 0, rs_cnt = 0;
    logic [7:0] ws_port, ws_out, ws_prev, rs_port, rs_prev, prev_pid;

    always @(negedge clk) begin
        if (bus.write_strobe) begin
            ws_cnt++;
            ws_port = bus.port_id;
            ws_out  = bus.out_port;
            ws_prev = prev_pid;
        end
        if (bus.read_strobe) begin
            rs_cnt++;
            rs_port = bus.port_id;
            rs_prev = prev_pid;
        end
        prev_pid = bus.port_id;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        bit ok = 0;
        bus.cmd_data  = b;
        bus.cmd_valid = 1'b1;
        for (int n = 0; n < 100; n++) begin
            if (bus.cmd_ready) begin
                ok = 1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle_cmd();
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = 8'h00;
    endtask

    task automatic get_rsp(input string tag);
        bit ok = 0;
        logic [7:0] e;
        for (int n = 0; n < 100; n++) begin
            if (bus.rsp_valid) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            chk({tag, "_rsp_timeout"}, 32'd0, 32'd1);
        end else if (exp_q.size() == 0) begin
            chk({tag, "_unexpected_rsp"}, {24'd0, bus.rsp_data}, 32'hFFFF);
        end else begin
            e = exp_q.pop_front();
            chk(tag, {24'd0, bus.rsp_data}, {24'd0, e});
            bus.rsp_ready = 1'b1;
            @(negedge clk);
            bus.rsp_ready = 1'b0;
            chk({tag, "_valid_drop"}, {31'd0, bus.rsp_valid}, 32'd0);
            chk({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
        end
    endtask

    int ws0, rs0;
    logic [7:0] held;
    bit saw_rsp;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'h81);
        mem[8'h03] = 8'h3C;
        mem[8'h01] = 8'h77;
        mem[8'h20] = 8'h5A;
        mem[8'h44] = 8'hC3;
        bus.cmd_data  = 8'h00;
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_port_id", {24'd0, bus.port_id}, 32'd0);
        chk("rst_rsp_data", {24'd0, bus.rsp_data}, 32'd0);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", {31'd0, bus.cmd_ready}, 32'd1);

        // Write 57,10,A5
        ws0 = ws_cnt; rs0 = rs_cnt;
        send(8'h57); send(8'h10); send(8'hA5); idle_cmd();
        exp_q.push_back(8'h2E);
        get_rsp("wr_rsp");
        chk("wr_strobes", ws_cnt - ws0, 1);
        chk("wr_port", {24'd0, ws_port}, 32'h10);
        chk("wr_data", {24'd0, ws_out}, 32'hA5);
        chk("wr_setup_port", {24'd0, ws_prev}, 32'h10);
        chk("wr_no_rd", rs_cnt - rs0, 0);
        chk("wr_port_hold", {24'd0, bus.port_id}, 32'h10);

        // Read 52,03
        ws0 = ws_cnt; rs0 = rs_cnt;
        send(8'h52); send(8'h03); idle_cmd();
        exp_q.push_back(8'h3C);
        get_rsp("rd_rsp");
        chk("rd_strobes", rs_cnt - rs0, 1);
        chk("rd_port", {24'd0, rs_port}, 32'h03);
        chk("rd_setup_port", {24'd0, rs_prev}, 32'h03);
        chk("rd_no_wr", ws_cnt - ws0, 0);

        // Bad opcode, then read 52,01; 'W' as address is not an opcode
        ws0 = ws_cnt; rs0 = rs_cnt;
        send(8'h41); idle_cmd();
        exp_q.push_back(8'h3F);
        get_rsp("bad_rsp");
        chk("bad_no_strobe", (ws_cnt - ws0) + (rs_cnt - rs0), 0);
        send(8'h52); send(8'h01); idle_cmd();
        exp_q.push_back(8'h77);
        get_rsp("rd01_rsp");
        mem[8'h57] = 8'h99;
        send(8'h52); send(8'h57); idle_cmd();
        exp_q.push_back(8'h99);
        get_rsp("rd57_rsp");

        // Response stall
        send(8'h52); send(8'h44); idle_cmd();
        exp_q.push_back(8'hC3);
        for (int n = 0; n < 20 && !bus.rsp_valid; n++) @(negedge clk);
        held = bus.rsp_data;
        for (int n = 0; n < 20; n++) begin
            chk("stall_valid", {31'd0, bus.rsp_valid}, 32'd1);
            chk("stall_data", {24'd0, bus.rsp_data}, {24'd0, held});
            chk("stall_ready", {31'd0, bus.cmd_ready}, 32'd0);
            @(negedge clk);
        end
        get_rsp("stall_rsp");

        // Timeout in GET_DATA after 8 idle cycles
        ws0 = ws_cnt; rs0 = rs_cnt;
        send(8'h57); send(8'h20); idle_cmd();
        repeat (7) @(negedge clk);
        chk("tmo_busy_7", {31'd0, bus.busy}, 32'd1);
        @(negedge clk);
        chk("tmo_busy_8", {31'd0, bus.busy}, 32'd0);
        repeat (3) @(negedge clk);
        chk("tmo_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
        chk("tmo_no_strobe", (ws_cnt - ws0) + (rs_cnt - rs0), 0);
        send(8'h52); send(8'h20); idle_cmd();
        exp_q.push_back(8'h5A);
        get_rsp("tmo_fresh_rd");

        // Byte on last allowed cycle is accepted
        ws0 = ws_cnt;
        send(8'h57); send(8'h21); idle_cmd();
        repeat (7) @(negedge clk);
        send(8'h6B); idle_cmd();
        exp_q.push_back(8'h2E);
        get_rsp("late_byte_rsp");
        chk("late_byte_wr", ws_cnt - ws0, 1);
        chk("late_byte_data", {24'd0, ws_out}, 32'h6B);

        // Async reset during BUS_STROBE of a write
        send(8'h57); send(8'h30); send(8'h11); idle_cmd();
        for (int n = 0; n < 10 && !bus.write_strobe; n++) @(negedge clk);
        chk("ar_strobe_seen", {31'd0, bus.write_strobe}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("ar_ws", {31'd0, bus.write_strobe}, 32'd0);
        chk("ar_busy", {31'd0, bus.busy}, 32'd0);
        chk("ar_port", {24'd0, bus.port_id}, 32'd0);
        chk("ar_out", {24'd0, bus.out_port}, 32'd0);
        chk("ar_rsp", {24'd0, bus.rsp_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_rsp = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (bus.rsp_valid) saw_rsp = 1;
        end
        chk("ar_no_rsp", {31'd0, saw_rsp}, 32'd0);
        chk("sb_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pb_port_master.md
Name: pb_port_master

Overview:
- Command-driven initiator for the PicoBlaze port bus: parses a byte stream (normally fed by a UART receiver FIFO) into port write/read cycles and returns status/read bytes on a response stream (normally to a UART transmitter FIFO).
- Allows a host on the serial link to peek/poke any port-mapped peripheral (UART regs, GPIO, timers) without a PicoBlaze program; sits in place of, or muxed with, the KCPSM6 port outputs.

Parameters:
- WR_OPCODE, 8'h57, command byte starting a write ('W').
- RD_OPCODE, 8'h52, command byte starting a read ('R').
- ACK_CODE, 8'h2E, response byte after a completed write.
- ERR_CODE, 8'h3F, response byte for an unknown opcode.
- TIMEOUT_CYCLES, 16'd50000, max idle clocks between bytes of one command before it is discarded.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- cmd_data  input  8  command stream byte.
- cmd_valid  input  1  cmd_data valid.
- cmd_ready  output  1  block accepts cmd_data this cycle (transfer = valid & ready).
- rsp_data  output  8  response byte.
- rsp_valid  output  1  rsp_data valid.
- rsp_ready  input  1  sink accepts rsp_data (transfer = valid & ready).
- port_id  output  8  port address to peripherals.
- out_port  output  8  write data to peripherals.
- in_port  input  8  read data muxed from peripherals.
- write_strobe  output  1  one-cycle write qualifier.
- read_strobe  output  1  one-cycle read qualifier.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (reset low, async): state IDLE; port_id, out_port, rsp_data = 8'h00; write_strobe, read_strobe, rsp_valid, busy = 0; timeout counter = 0. Strobes drop immediately even mid-cycle; partial commands are lost.
- States: IDLE, GET_ADDR, GET_DATA, BUS_SETUP, BUS_STROBE, RESP.
- cmd_ready = 1 only in IDLE, GET_ADDR, GET_DATA; 0 elsewhere.
- IDLE: on cmd transfer: byte==WR_OPCODE or RD_OPCODE -> latch op, GET_ADDR; any other byte -> rsp_data=ERR_CODE, RESP.
- GET_ADDR: on transfer latch port_id; write op -> GET_DATA; read op -> BUS_SETUP.
- GET_DATA: on transfer latch out_port -> BUS_SETUP.
- BUS_SETUP: one cycle, port_id/out_port stable, strobes low -> BUS_STROBE.
- BUS_STROBE: one cycle, write_strobe=1 (write) or read_strobe=1 (read); on the edge ending this cycle read captures in_port into rsp_data, write loads rsp_data=ACK_CODE -> RESP.
- port_id is stable for both BUS_SETUP and BUS_STROBE (2 cycles), matching KCPSM6 port timing; exactly one strobe pulse per command.
- RESP: rsp_valid=1, rsp_data held stable until rsp_ready; on transfer rsp_valid=0 next cycle -> IDLE. Back-to-back commands: min 5 cycles from opcode transfer (read) to rsp_valid if bytes arrive every cycle; write 6.
- port_id, out_port retain last values outside a cycle (not cleared to 0 after the cycle).
- Timeout: in GET_ADDR/GET_DATA, counter increments each cycle with no transfer, clears on transfer and on entering IDLE. When counter reaches TIMEOUT_CYCLES-1 without a transfer, return to IDLE next edge with no bus cycle and no response. Transfer on that same cycle wins (byte accepted, no timeout). Counter saturates; never wraps.
- No timeout in RESP: a stalled sink blocks indefinitely; cmd_ready stays 0 (backpressure to UART FIFO).
- Opcode match is exact 8-bit compare; address/data bytes are never interpreted as opcodes.

Test Plan:
- Write: send 57,10,A5 back-to-back -> after BUS_SETUP, write_strobe high exactly 1 cycle with port_id=10, out_port=A5; port_id=10 also the cycle before; response 2E; read_strobe never high.
- Read: send 52,03 with in_port=3C when port_id==03 -> read_strobe 1 cycle, port_id=03 for 2 cycles, response 3C; write_strobe never high.
- Bad opcode: send 41 -> response 3F, no strobe; then 52,01 with in_port=77 -> response 77.
- Response stall: read with rsp_ready=0 for 20 cycles -> rsp_valid high, rsp_data constant, cmd_ready=0 throughout; release -> single transfer, back to IDLE.
- Timeout (TIMEOUT_CYCLES=8 in bench): send 57,20 then wait 8 cycles -> IDLE, busy=0, no strobe/response; next 52,20 executes as a fresh read. Byte arriving on cycle 7 is accepted.
- Async reset: assert reset low during BUS_STROBE of a write -> write_strobe and busy 0 before next clock edge, outputs at reset values, no response after release.
